// File: rtl/bn128_pkg.sv
// rtl/bn128_pkg.sv - BN128 base-field constants and field-element type
//
// Purpose : shared home for the BN128 prime and its element type, used as
//           the default modulus by the modular arithmetic pipes.
// Ports   : none (package)
package bn128_pkg;

  localparam int FE_BITS = 256;

  typedef logic [FE_BITS-1:0] fe_t;

  // BN128 (alt_bn128 / BN254) base-field prime q.
  localparam fe_t P = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

endpackage

// File: rtl/mod_adder_pipe_pkg.sv
// rtl/mod_adder_pipe_pkg.sv - carry-chain segmentation helpers for mod_adder_pipe
//
// Purpose : elaboration-time functions that split a BITS-wide carry chain
//           into LEVEL segments, one per pipeline stage.
// Ports   : none (package)
package mod_adder_pipe_pkg;

  // Width of every segment except possibly the last (ceil(bits/level)).
  function automatic int seg_size(input int bits, input int level);
    return (bits + level - 1) / level;
  endfunction

  // First bit handled by stage idx, clamped so trailing stages past the
  // top of the word become empty pass-through stages.
  function automatic int seg_lo(input int idx, input int bits, input int level);
    int lo;
    lo = idx * seg_size(bits, level);
    return (lo > bits) ? bits : lo;
  endfunction

  // One past the last bit handled by stage idx.
  function automatic int seg_hi(input int idx, input int bits, input int level);
    return seg_lo(idx + 1, bits, level);
  endfunction

endpackage

// File: rtl/mod_adder_pipe.sv
// rtl/mod_adder_pipe.sv - pipelined modular adder, (a+b) mod P over LEVEL stages
//
// Purpose : computes (a+b) mod P for a,b < P. The sum s=a+b and the trial
//           difference d=s-P are both built as carry/borrow chains cut into
//           LEVEL segments, one segment per stage, with the carry and borrow
//           registered between stages. The last stage picks d when it is
//           non-negative, otherwise s.
// Ports   : i_clk      - sole clock, rising edge
//           i_rst      - synchronous reset, active low
//           i_add_dat  - operands: [BITS-1:0]=a, [2*BITS-1:BITS]=b
//           i_add_val  - operand pair valid
//           i_add_rdy  - pipe can accept (o_add_rdy or empty output stage)
//           i_add_ctl  - sideband control, travels with the data
//           i_add_sop  - start of packet, travels with the data
//           i_add_eop  - end of packet, travels with the data
//           o_add_dat  - result (a+b) mod P
//           o_add_val  - result valid (registered, independent of o_add_rdy)
//           o_add_rdy  - downstream ready
//           o_add_ctl  - sideband control aligned with o_add_dat
//           o_add_sop  - start of packet aligned with o_add_dat
//           o_add_eop  - end of packet aligned with o_add_dat
//           o_add_err  - always 0
//           o_add_mod  - always 0
module mod_adder_pipe
  import mod_adder_pipe_pkg::*;
#(
  parameter int               BITS     = 256,
  parameter logic [BITS-1:0]  P        = bn128_pkg::P,
  parameter int               CTL_BITS = 8,
  parameter int               LEVEL    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,

  input  logic [2*BITS-1:0]   i_add_dat,
  input  logic                i_add_val,
  output logic                i_add_rdy,
  input  logic [CTL_BITS-1:0] i_add_ctl,
  input  logic                i_add_sop,
  input  logic                i_add_eop,

  output logic [BITS-1:0]     o_add_dat,
  output logic                o_add_val,
  input  logic                o_add_rdy,
  output logic [CTL_BITS-1:0] o_add_ctl,
  output logic                o_add_sop,
  output logic                o_add_eop,
  output logic                o_add_err,
  output logic                o_add_mod
);

  // The whole pipe moves as one: every stage loads when the output can
  // drain or is empty, otherwise every stage holds.
  logic adv;
  assign adv = i_add_rdy;

  for (genvar i = 0; i < LEVEL; i++) begin : g_stage
    localparam int LO = seg_lo(i, BITS, LEVEL);
    localparam int HI = seg_hi(i, BITS, LEVEL);
    localparam int W  = HI - LO;

    // s_* carries sum bits below this stage's segment and still-unused a
    // bits above it; d_* does the same with difference bits and b bits.
    // Every register bit is therefore consumed further down the pipe.
    logic [BITS-1:0]     s_i, d_i;
    logic                c_i, bw_i;
    logic [CTL_BITS-1:0] ctl_i;
    logic                sop_i, eop_i, val_i;

    if (i == 0) begin : g_src
      assign s_i   = i_add_dat[BITS-1:0];
      assign d_i   = i_add_dat[2*BITS-1:BITS];
      assign c_i   = 1'b0;
      assign bw_i  = 1'b0;
      assign ctl_i = i_add_ctl;
      assign sop_i = i_add_sop;
      assign eop_i = i_add_eop;
      assign val_i = i_add_val;
    end else begin : g_src
      assign s_i   = g_stage[i-1].s_q;
      assign d_i   = g_stage[i-1].d_q;
      assign c_i   = g_stage[i-1].c_q;
      assign bw_i  = g_stage[i-1].bw_q;
      assign ctl_i = g_stage[i-1].ctl_q;
      assign sop_i = g_stage[i-1].sop_q;
      assign eop_i = g_stage[i-1].eop_q;
      assign val_i = g_stage[i-1].val_q;
    end

    logic [BITS-1:0] s_n, d_n;
    logic            c_n, bw_n;

    if (W > 0) begin : g_seg
      localparam logic [W-1:0] P_SEG = P[LO +: W];

      logic [W:0] sum_seg;
      logic [W:0] dif_seg;

      assign sum_seg = {1'b0, s_i[LO +: W]} + {1'b0, d_i[LO +: W]} + {{W{1'b0}}, c_i};
      // The subtraction runs on this segment's fresh sum bits, so the
      // borrow chain trails the carry chain inside the same stage.
      assign dif_seg = {1'b0, sum_seg[W-1:0]} - {1'b0, P_SEG} - {{W{1'b0}}, bw_i};

      always_comb begin
        s_n            = s_i;
        d_n            = d_i;
        s_n[LO +: W]   = sum_seg[W-1:0];
        d_n[LO +: W]   = dif_seg[W-1:0];
      end

      assign c_n  = sum_seg[W];
      assign bw_n = dif_seg[W];
    end else begin : g_seg
      // Stage past the top of the word when LEVEL does not divide BITS.
      assign s_n  = s_i;
      assign d_n  = d_i;
      assign c_n  = c_i;
      assign bw_n = bw_i;
    end

    logic [BITS-1:0]     s_q, d_q;
    logic                c_q, bw_q;
    logic [CTL_BITS-1:0] ctl_q;
    logic                sop_q, eop_q, val_q;

    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        val_q <= 1'b0;
      end else if (adv) begin
        val_q <= val_i;
      end
      if (adv) begin
        s_q   <= s_n;
        d_q   <= d_n;
        c_q   <= c_n;
        bw_q  <= bw_n;
        ctl_q <= ctl_i;
        sop_q <= sop_i;
        eop_q <= eop_i;
      end
    end
  end

  // d = s - P is negative only when the low BITS bits borrowed and the sum
  // did not overflow into bit BITS.
  logic d_neg;
  assign d_neg = g_stage[LEVEL-1].bw_q & ~g_stage[LEVEL-1].c_q;

  assign o_add_dat = d_neg ? g_stage[LEVEL-1].s_q : g_stage[LEVEL-1].d_q;
  assign o_add_ctl = g_stage[LEVEL-1].ctl_q;
  assign o_add_sop = g_stage[LEVEL-1].sop_q;
  assign o_add_eop = g_stage[LEVEL-1].eop_q;

  // Masked by reset so nothing in flight escapes while reset is held.
  assign o_add_val = g_stage[LEVEL-1].val_q & i_rst;
  assign i_add_rdy = i_rst & (o_add_rdy | ~o_add_val);

  assign o_add_err = 1'b0;
  assign o_add_mod = 1'b0;

endmodule

// File: tb/tb_mod_adder_pipe.sv
// tb/tb_mod_adder_pipe.sv - scoreboard bench for mod_adder_pipe at LEVEL 2, 1 and 4
module tb_mod_adder_pipe;

  localparam int BITS = 256;
  localparam int CB   = 8;
  localparam logic [BITS-1:0] PM   = bn128_pkg::P;
  localparam logic [BITS-1:0] ZERO = '0;
  localparam logic [BITS-1:0] ONE  = 256'd1;

  logic              clk;
  logic              rst_n;
  logic [2*BITS-1:0] in_dat;
  logic              in_val;
  logic [CB-1:0]     in_ctl;
  logic              in_sop, in_eop;
  logic              out_rdy;
  logic              one_b;

  logic              rdy_m, rdy_1, rdy_4;
  logic              val_x;

  logic [BITS-1:0]   m_dat, x1_dat, x4_dat;
  logic              m_val, x1_val, x4_val;
  logic [CB-1:0]     m_ctl, x1_ctl, x4_ctl;
  logic              m_sop, x1_sop, x4_sop;
  logic              m_eop, x1_eop, x4_eop;
  logic              m_err, x1_err, x4_err;
  logic              m_mod, x1_mod, x4_mod;

  // The extra instances only see items the LEVEL=2 instance accepted.
  assign val_x = in_val & rdy_m;

  mod_adder_pipe #(.BITS(BITS), .P(PM), .CTL_BITS(CB), .LEVEL(2)) u_dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_add_dat(in_dat), .i_add_val(in_val), .i_add_rdy(rdy_m),
    .i_add_ctl(in_ctl), .i_add_sop(in_sop), .i_add_eop(in_eop),
    .o_add_dat(m_dat), .o_add_val(m_val), .o_add_rdy(out_rdy),
    .o_add_ctl(m_ctl), .o_add_sop(m_sop), .o_add_eop(m_eop),
    .o_add_err(m_err), .o_add_mod(m_mod)
  );

  mod_adder_pipe #(.BITS(BITS), .P(PM), .CTL_BITS(CB), .LEVEL(1)) u_dut_l1 (
    .i_clk(clk), .i_rst(rst_n),
    .i_add_dat(in_dat), .i_add_val(val_x), .i_add_rdy(rdy_1),
    .i_add_ctl(in_ctl), .i_add_sop(in_sop), .i_add_eop(in_eop),
    .o_add_dat(x1_dat), .o_add_val(x1_val), .o_add_rdy(one_b),
    .o_add_ctl(x1_ctl), .o_add_sop(x1_sop), .o_add_eop(x1_eop),
    .o_add_err(x1_err), .o_add_mod(x1_mod)
  );

  mod_adder_pipe #(.BITS(BITS), .P(PM), .CTL_BITS(CB), .LEVEL(4)) u_dut_l4 (
    .i_clk(clk), .i_rst(rst_n),
    .i_add_dat(in_dat), .i_add_val(val_x), .i_add_rdy(rdy_4),
    .i_add_ctl(in_ctl), .i_add_sop(in_sop), .i_add_eop(in_eop),
    .o_add_dat(x4_dat), .o_add_val(x4_val), .o_add_rdy(one_b),
    .o_add_ctl(x4_ctl), .o_add_sop(x4_sop), .o_add_eop(x4_eop),
    .o_add_err(x4_err), .o_add_mod(x4_mod)
  );

  typedef struct packed {
    logic [BITS-1:0] dat;
    logic [CB-1:0]   ctl;
    logic            sop;
    logic            eop;
    logic            lat;
    int              cyc;
  } exp_t;

  exp_t sb [3][$];

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  bit   lat_chk = 0;
  bit   rnd_mode = 0;
  bit   prev_stall = 0;
  logic [BITS-1:0] prev_dat;
  logic [CB-1:0]   prev_ctl;

  task automatic check_val(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BITS-1:0] ref_add(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    logic [BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return BITS'(s % {1'b0, PM});
  endfunction

  function automatic logic [BITS-1:0] rand_fe();
    logic [BITS-1:0] r;
    for (int w = 0; w < BITS / 32; w++) r[32*w +: 32] = $urandom;
    return r % PM;
  endfunction

  task automatic score(input int k, input int lvl, input logic ov, input logic ordy,
                       input logic [BITS-1:0] od, input logic [CB-1:0] oc,
                       input logic os, input logic oe, input logic oerr, input logic omod,
                       input logic ix);
    exp_t e;
    if (ov && ordy) begin
      check_val($sformatf("L%0d_out_expected", lvl), BITS'(sb[k].size() != 0), ONE);
      if (sb[k].size() != 0) begin
        e = sb[k].pop_front();
        check_val($sformatf("L%0d_dat", lvl), od, e.dat);
        check_val($sformatf("L%0d_ctl", lvl), BITS'(oc), BITS'(e.ctl));
        check_val($sformatf("L%0d_sop_eop", lvl), BITS'({os, oe}), BITS'({e.sop, e.eop}));
        check_val($sformatf("L%0d_err_mod", lvl), BITS'({oerr, omod}), ZERO);
        if (e.lat) check_val($sformatf("L%0d_latency", lvl), BITS'(cyc - e.cyc), BITS'(lvl));
      end
    end
    if (ix) begin
      e.dat = ref_add(in_dat[BITS-1:0], in_dat[2*BITS-1:BITS]);
      e.ctl = in_ctl;
      e.sop = in_sop;
      e.eop = in_eop;
      e.lat = lat_chk;
      e.cyc = cyc;
      sb[k].push_back(e);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: transfers are decided by the values stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      score(0, 2, m_val, out_rdy, m_dat, m_ctl, m_sop, m_eop, m_err, m_mod, in_val & rdy_m);
      score(1, 1, x1_val, one_b, x1_dat, x1_ctl, x1_sop, x1_eop, x1_err, x1_mod, val_x & rdy_1);
      score(2, 4, x4_val, one_b, x4_dat, x4_ctl, x4_sop, x4_eop, x4_err, x4_mod, val_x & rdy_4);
      if (prev_stall && rst_n) begin
        check_val("stall_val", BITS'(m_val), ONE);
        check_val("stall_dat", m_dat, prev_dat);
        check_val("stall_ctl", BITS'(m_ctl), BITS'(prev_ctl));
      end
      prev_stall = rst_n && m_val && !out_rdy;
      prev_dat   = m_dat;
      prev_ctl   = m_ctl;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) out_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                      input logic [CB-1:0] c, input logic s, input logic e);
    int n;
    n      = 0;
    in_dat = {b, a};
    in_ctl = c;
    in_sop = s;
    in_eop = e;
    in_val = 1'b1;
    @(negedge clk);
    while (!rdy_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_m) check_val("send_timeout", BITS'(rdy_m), ONE);
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_empty", BITS'(sb[0].size() + sb[1].size() + sb[2].size()), ZERO);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    in_val  = 1'b0;
    in_dat  = '0;
    in_ctl  = '0;
    in_sop  = 1'b0;
    in_eop  = 1'b0;
    out_rdy = 1'b1;
    one_b   = 1'b1;

    repeat (3) begin
      @(negedge clk);
      check_val("rst_oval", BITS'(m_val), ZERO);
      check_val("rst_irdy", BITS'(rdy_m), ZERO);
      check_val("rst_err_mod", BITS'({m_err, m_mod}), ZERO);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("release_irdy", BITS'(rdy_m), ONE);
    @(posedge clk);
    #1;

    // Directed values and the modulus boundaries.
    lat_chk = 1'b1;
    send(256'd5, 256'd7, 8'h3C, 1'b1, 1'b0);
    send(PM - ONE, ONE, 8'h01, 1'b0, 1'b0);
    send(PM - ONE, PM - ONE, 8'h02, 1'b0, 1'b0);
    send(ZERO, ZERO, 8'h03, 1'b0, 1'b0);
    send(PM - 256'd2, ONE, 8'h04, 1'b0, 1'b0);
    send(PM - 256'd3, 256'd3, 8'h05, 1'b0, 1'b1);
    drain();

    // Back-to-back random pairs, ctl carries the index.
    for (int i = 0; i < 1000; i++) begin
      send(rand_fe(), rand_fe(), i[7:0], i == 0, i == 999);
    end
    drain();

    // Random downstream back-pressure.
    lat_chk  = 1'b0;
    rnd_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(rand_fe(), rand_fe(), i[7:0], 1'b0, 1'b0);
    end
    rnd_mode = 1'b0;
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    drain();
    lat_chk = 1'b1;

    // Reset with items in flight: nothing of them may emerge afterwards.
    send(256'd10, 256'd20, 8'hA0, 1'b1, 1'b0);
    send(256'd30, 256'd40, 8'hA1, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midrst_oval", BITS'(m_val), ZERO);
    check_val("midrst_irdy", BITS'(rdy_m), ZERO);
    @(negedge clk);
    check_val("midrst_oval_l4", BITS'(x4_val), ZERO);
    for (int k = 0; k < 3; k++) sb[k].delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rerelease_irdy", BITS'(rdy_m), ONE);
    @(posedge clk);
    #1;
    send(256'd1, 256'd2, 8'h55, 1'b1, 1'b1);
    drain();
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
